register_file_bist: RTL and testbench

- Hardware initiator for the 2-read/1-write register file.
- Walks every register through a shift-in-ones then shift-in-zeros pattern. After every write it reads back through port 0, then port 1, then both ports together.
- Captures the first mismatch and reports pass/fail.
- Sits beside register_file behind a test mux. Used for power-on self-test and silicon debug.

---
 rtl/register_file_bist_if.sv | 22 ++
 rtl/register_file_bist.sv | 123 ++++++++++++
 tb/tb_register_file_bist.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/register_file_bist_if.sv
// register_file_bist_if: register-file port bundle; master (BIST) drives rf_write_en/rf_waddr/rf_wdata/rf_read_en/rf_raddr_0/rf_raddr_1 and samples rf_rdata_0/rf_rdata_1, slave (register file) the reverse
interface register_file_bist_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                  rf_write_en;
  logic [ADDR_WIDTH-1:0] rf_waddr;
  logic [DATA_WIDTH-1:0] rf_wdata;
  logic [1:0]            rf_read_en;
  logic [ADDR_WIDTH-1:0] rf_raddr_0;
  logic [ADDR_WIDTH-1:0] rf_raddr_1;
  logic [DATA_WIDTH-1:0] rf_rdata_0;
  logic [DATA_WIDTH-1:0] rf_rdata_1;
  modport master (
    output rf_write_en, rf_waddr, rf_wdata, rf_read_en, rf_raddr_0, rf_raddr_1,
    input  rf_rdata_0, rf_rdata_1
  );
  modport slave (
    input  rf_write_en, rf_waddr, rf_wdata, rf_read_en, rf_raddr_0, rf_raddr_1,
    output rf_rdata_0, rf_rdata_1
  );
endinterface

// File: rtl/register_file_bist.sv
// register_file_bist: walking-ones/zeros self-test of a 2R/1W register file; ports clk, reset (sync, active-high), start in; busy, done, pass, fail_addr, fail_port, fail_expected, fail_actual out; rf is the register-file master bus
module register_file_bist #(
  parameter int NUM_REGS   = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [1:0]            fail_port,
  output logic [DATA_WIDTH-1:0] fail_expected,
  output logic [DATA_WIDTH-1:0] fail_actual,
  register_file_bist_if.master  rf
);
  localparam int SW = $clog2(2 * DATA_WIDTH);
  typedef enum logic [2:0] {IDLE, WRITE, RD_P0, RD_P1, RD_BOTH, DONE} state_t;
  state_t                state;
  logic [DATA_WIDTH-1:0] pat, next_pat;
  logic [ADDR_WIDTH-1:0] addr, next_addr;
  logic [SW-1:0]         step, next_step;
  logic                  last_step, last_reg;
  logic [1:0]            miss;
  always_comb begin
    last_step = step == SW'(2 * DATA_WIDTH - 1);
    last_reg  = addr == ADDR_WIDTH'(NUM_REGS - 1);
    next_step = last_step ? '0 : step + SW'(1);
    next_addr = last_step ? addr + ADDR_WIDTH'(1) : addr;
    next_pat  = {pat[DATA_WIDTH-2:0], next_step < SW'(DATA_WIDTH)};
    miss[0]   = (state == RD_P0 || state == RD_BOTH) && rf.rf_rdata_0 != pat;
    miss[1]   = (state == RD_P1 || state == RD_BOTH) && rf.rf_rdata_1 != pat;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      fail_addr      <= '0;
      fail_port      <= '0;
      fail_expected  <= '0;
      fail_actual    <= '0;
      pat            <= '0;
      addr           <= '0;
      step           <= '0;
      rf.rf_write_en <= 1'b0;
      rf.rf_waddr    <= '0;
      rf.rf_wdata    <= '0;
      rf.rf_read_en  <= 2'b00;
      rf.rf_raddr_0  <= '0;
      rf.rf_raddr_1  <= '0;
    end else begin
      rf.rf_write_en <= 1'b0;
      rf.rf_waddr    <= '0;
      rf.rf_wdata    <= '0;
      rf.rf_read_en  <= 2'b00;
      rf.rf_raddr_0  <= '0;
      rf.rf_raddr_1  <= '0;
      if (miss != 2'b00) begin
        state         <= DONE;
        busy          <= 1'b0;
        done          <= 1'b1;
        pass          <= 1'b0;
        fail_addr     <= addr;
        fail_port     <= miss;
        fail_expected <= pat;
        fail_actual   <= miss[0] ? rf.rf_rdata_0 : rf.rf_rdata_1;
      end else begin
        case (state)
          IDLE, DONE: if (start) begin
            state          <= WRITE;
            busy           <= 1'b1;
            done           <= 1'b0;
            pass           <= 1'b0;
            fail_addr      <= '0;
            fail_port      <= '0;
            fail_expected  <= '0;
            fail_actual    <= '0;
            addr           <= '0;
            step           <= '0;
            pat            <= DATA_WIDTH'(1);
            rf.rf_write_en <= 1'b1;
            rf.rf_wdata    <= DATA_WIDTH'(1);
          end
          WRITE: begin
            state         <= RD_P0;
            rf.rf_read_en <= 2'b01;
            rf.rf_raddr_0 <= addr;
          end
          RD_P0: begin
            state         <= RD_P1;
            rf.rf_read_en <= 2'b10;
            rf.rf_raddr_1 <= addr;
          end
          RD_P1: begin
            state         <= RD_BOTH;
            rf.rf_read_en <= 2'b11;
            rf.rf_raddr_0 <= addr;
            rf.rf_raddr_1 <= addr;
          end
          RD_BOTH: if (last_step && last_reg) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= 1'b1;
          end else begin
            state          <= WRITE;
            step           <= next_step;
            addr           <= next_addr;
            pat            <= next_pat;
            rf.rf_write_en <= 1'b1;
            rf.rf_waddr    <= next_addr;
            rf.rf_wdata    <= next_pat;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_register_file_bist.sv
// tb_register_file_bist: scoreboard bench driving register_file_bist against a register-file model with injectable stuck-at read faults
module tb_register_file_bist;
  localparam int NR = 32;
  localparam int DW = 32;
  localparam int AW = 5;
  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          busy, done, pass;
  logic [AW-1:0] fail_addr;
  logic [1:0]    fail_port;
  logic [DW-1:0] fail_expected, fail_actual;
  register_file_bist_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
  register_file_bist #(.NUM_REGS(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .busy(busy),
    .done(done),
    .pass(pass),
    .fail_addr(fail_addr),
    .fail_port(fail_port),
    .fail_expected(fail_expected),
    .fail_actual(fail_actual),
    .rf(bus)
  );
  always #5 clk = ~clk;
  int          f_addr = -1;
  logic [31:0] f_clr0 = '0, f_set0 = '0, f_clr1 = '0, f_set1 = '0;
  logic [DW-1:0] mem [NR];
  always @(posedge clk) if (bus.rf_write_en) mem[bus.rf_waddr] <= bus.rf_wdata;
  always_comb begin
    bus.rf_rdata_0 = '0;
    bus.rf_rdata_1 = '0;
    if (bus.rf_read_en[0])
      bus.rf_rdata_0 = int'(bus.rf_raddr_0) == f_addr ? (mem[bus.rf_raddr_0] & ~f_clr0) | f_set0 : mem[bus.rf_raddr_0];
    if (bus.rf_read_en[1])
      bus.rf_rdata_1 = int'(bus.rf_raddr_1) == f_addr ? (mem[bus.rf_raddr_1] & ~f_clr1) | f_set1 : mem[bus.rf_raddr_1];
  end
  typedef struct packed {logic [3:0] kind; logic [7:0] addr; logic [31:0] data;} op_t;
  typedef struct {bit pass; int addr; int port; logic [31:0] expv; logic [31:0] actv; int cycles;} res_t;
  op_t  exp_q[$];
  res_t res_q[$];
  int   n_chk = 0, n_pass = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
      if (n_chk - n_pass >= 40) begin
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
      end
    end
  endtask
  function automatic logic [31:0] flt(input int port, input int a, input logic [31:0] v);
    if (a != f_addr) return v;
    return port == 0 ? (v & ~f_clr0) | f_set0 : (v & ~f_clr1) | f_set1;
  endfunction
  task automatic plan();
    int   n = 0;
    bit   hit = 0;
    res_t r;
    r.pass = 1; r.addr = 0; r.port = 0; r.expv = '0; r.actv = '0;
    for (int a = 0; a < NR && !hit; a++)
      for (int s = 0; s < 2 * DW && !hit; s++) begin
        logic [31:0] p, v0, v1;
        p  = s < DW ? 32'((64'd1 << (s + 1)) - 64'd1) : 32'hFFFF_FFFF << (s - DW + 1);
        v0 = flt(0, a, p);
        v1 = flt(1, a, p);
        exp_q.push_back('{4'd0, 8'(a), p});
        exp_q.push_back('{4'd1, 8'(a), 32'd0});
        n += 2;
        if (v0 != p) begin
          hit = 1; r.port = 1; r.actv = v0;
        end else begin
          exp_q.push_back('{4'd2, 8'(a), 32'd0});
          n++;
          if (v1 != p) begin
            hit = 1; r.port = 2; r.actv = v1;
          end else begin
            exp_q.push_back('{4'd3, 8'(a), 32'd0});
            n++;
          end
        end
        if (hit) begin
          r.pass = 0; r.addr = a; r.expv = p;
        end
      end
    r.cycles = n;
    res_q.push_back(r);
  endtask
  bit   mon_en = 0;
  logic prev_done = 1'b0, prev_busy = 1'b0;
  int   bcnt = 0;
  always @(negedge clk) begin
    op_t  o;
    res_t r;
    if (mon_en) begin
      if (bus.rf_write_en || bus.rf_read_en != 2'b00) begin
        o.kind = bus.rf_write_en && bus.rf_read_en != 2'b00 ? 4'hF : bus.rf_write_en ? 4'd0 : {2'b00, bus.rf_read_en};
        o.addr = o.kind == 4'd0 ? 8'(bus.rf_waddr) : o.kind == 4'd1 ? 8'(bus.rf_raddr_0) :
                 o.kind == 4'd2 ? 8'(bus.rf_raddr_1) : bus.rf_raddr_0 == bus.rf_raddr_1 ? 8'(bus.rf_raddr_0) : 8'hFF;
        o.data = o.kind == 4'd0 ? bus.rf_wdata : 32'd0;
        if (exp_q.size() == 0) chk("unexpected_bus_op", 64'(o), 64'hFFFF_FFFF_FFFF_FFFF);
        else chk("bus_op", 64'(o), 64'(exp_q.pop_front()));
      end
      if (busy) bcnt = prev_busy ? bcnt + 1 : 1;
      if (done && !prev_done) begin
        if (res_q.size() == 0) chk("unexpected_done", 64'(done), 64'(0));
        else begin
          r = res_q.pop_front();
          chk("res_pass", 64'(pass), 64'(r.pass));
          chk("res_fail_addr", 64'(fail_addr), 64'(r.addr));
          chk("res_fail_port", 64'(fail_port), 64'(r.port));
          chk("res_fail_expected", 64'(fail_expected), 64'(r.expv));
          chk("res_fail_actual", 64'(fail_actual), 64'(r.actv));
          chk("res_busy_cycles", 64'(bcnt), 64'(r.cycles));
          chk("res_ops_drained", 64'(exp_q.size()), 64'(0));
        end
      end
      prev_done = done;
      prev_busy = busy;
    end
  end
  task automatic clear_fault();
    f_addr = -1; f_clr0 = '0; f_set0 = '0; f_clr1 = '0; f_set1 = '0;
  endtask
  task automatic pulse();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask
  task automatic run_wait(input int budget, input bit noise);
    int n = 0;
    while (!done && n < budget) begin
      @(posedge clk);
      #1 start = noise && busy && ($urandom_range(0, 63) == 0);
      n++;
    end
    start = 1'b0;
    chk("done_timeout", 64'(done), 64'(1));
    @(posedge clk);
    #1;
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    mon_en = 1;
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_pass", 64'(pass), 64'(0));
    chk("rst_fail_addr", 64'(fail_addr), 64'(0));
    chk("rst_fail_port", 64'(fail_port), 64'(0));
    chk("rst_fail_expected", 64'(fail_expected), 64'(0));
    chk("rst_fail_actual", 64'(fail_actual), 64'(0));
    chk("rst_write_en", 64'(bus.rf_write_en), 64'(0));
    chk("rst_read_en", 64'(bus.rf_read_en), 64'(0));
    chk("rst_wdata", 64'(bus.rf_wdata), 64'(0));
    plan();
    pulse();
    run_wait(9000, 1);
    f_addr = 5; f_clr0 = 32'h80; f_clr1 = 32'h80;
    plan();
    pulse();
    run_wait(9000, 0);
    repeat (20) begin
      @(posedge clk);
      #1 chk("no_write_after_fail", 64'(bus.rf_write_en), 64'(0));
    end
    chk("fail_done_held", 64'(done), 64'(1));
    clear_fault();
    plan();
    pulse();
    chk("restart_done_clr", 64'(done), 64'(0));
    chk("restart_pass_clr", 64'(pass), 64'(0));
    chk("restart_addr_clr", 64'(fail_addr), 64'(0));
    chk("restart_port_clr", 64'(fail_port), 64'(0));
    chk("restart_exp_clr", 64'(fail_expected), 64'(0));
    chk("restart_act_clr", 64'(fail_actual), 64'(0));
    chk("restart_busy", 64'(busy), 64'(1));
    run_wait(9000, 0);
    f_addr = 0; f_set1 = 32'h8000_0000;
    plan();
    pulse();
    run_wait(100, 0);
    clear_fault();
    plan();
    pulse();
    repeat (999) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    exp_q.delete();
    res_q.delete();
    chk("midrst_busy", 64'(busy), 64'(0));
    chk("midrst_write_en", 64'(bus.rf_write_en), 64'(0));
    chk("midrst_read_en", 64'(bus.rf_read_en), 64'(0));
    chk("midrst_done", 64'(done), 64'(0));
    plan();
    pulse();
    run_wait(9000, 1);
    repeat (3) begin
      int          b, ports;
      bit          pol;
      logic [31:0] m;
      clear_fault();
      f_addr = $urandom_range(0, 7);
      b      = $urandom_range(0, 31);
      ports  = $urandom_range(1, 3);
      pol    = 1'($urandom_range(0, 1));
      m      = 32'd1 << b;
      if (ports[0]) begin
        if (pol) f_set0 = m;
        else f_clr0 = m;
      end
      if (ports[1]) begin
        if (pol) f_set1 = m;
        else f_clr1 = m;
      end
      plan();
      pulse();
      run_wait(9000, 0);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
